// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared encodings and sizes for the MEM stage and data memory
package mem_wb_stage_pkg;
   localparam logic MEM_SIZE_BYTE = 1'b0;
   localparam logic MEM_SIZE_WORD = 1'b1;
   localparam int   DM_ADDR_W     = 8;
endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// data_memory: big-endian byte array, synchronous write, combinational byte/word read
module data_memory
   import mem_wb_stage_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              e,
   input  logic              rw,
   input  logic              size,
   input  logic [ADDR_W-1:0] a,
   input  logic [31:0]       di,
   output logic [31:0]       dout
);
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] a0, a1, a2, a3;
   assign a0 = {a[ADDR_W-1:2], 2'b00};
   assign a1 = {a[ADDR_W-1:2], 2'b01};
   assign a2 = {a[ADDR_W-1:2], 2'b10};
   assign a3 = {a[ADDR_W-1:2], 2'b11};
   always_ff @(posedge clk) begin
      if (e && rw) begin
         if (size == MEM_SIZE_WORD) begin
            mem[a0] <= di[31:24];
            mem[a1] <= di[23:16];
            mem[a2] <= di[15:8];
            mem[a3] <= di[7:0];
         end else begin
            mem[a] <= di[7:0];
         end
      end
   end
   assign dout = (size == MEM_SIZE_WORD) ? {mem[a0], mem[a1], mem[a2], mem[a3]}
                                         : {24'b0, mem[a]};
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access, MEM-stage forwarding and the MEM/WB register
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W,
   parameter int DEPTH  = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_enable,
   input  logic        mem_load,
   input  logic        mem_write,
   input  logic        mem_size,
   input  logic        rf_enable,
   input  logic [31:0] dm_address,
   input  logic [31:0] mux_pd,
   input  logic [3:0]  mux_instr_i15_i12,
   output logic [3:0]  wb_rw,
   output logic        wb_le,
   output logic [31:0] wb_pw,
   output logic [31:0] mem_fwd_data,
   output logic [3:0]  mem_fwd_rd,
   output logic        mem_fwd_en,
   output logic        align_fault
);
   logic [ADDR_W-1:0] ea;
   logic [31:0]       ld_data;
   logic              load_sel, misalign;
   assign ea       = dm_address[ADDR_W-1:0];
   assign load_sel = mem_enable & mem_load & ~mem_write;
   assign misalign = mem_enable & (mem_size == MEM_SIZE_WORD) & (ea[1:0] != 2'b00);
   // gating with reset keeps a store from landing on an edge seen while reset is held
   data_memory #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dm (
      .clk  (clk),
      .e    (mem_enable & reset),
      .rw   (mem_write),
      .size (mem_size),
      .a    (ea),
      .di   (mux_pd),
      .dout (ld_data)
   );
   assign mem_fwd_data = load_sel ? ld_data : dm_address;
   assign mem_fwd_rd   = mux_instr_i15_i12;
   assign mem_fwd_en   = rf_enable;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_rw       <= '0;
         wb_le       <= 1'b0;
         wb_pw       <= '0;
         align_fault <= 1'b0;
      end else begin
         wb_rw       <= mux_instr_i15_i12;
         wb_le       <= rf_enable;
         wb_pw       <= mem_fwd_data;
         align_fault <= align_fault | misalign;
      end
   end
endmodule
